crack_sched: RTL

- Key-search scheduler for the ARC4 cracker.
- Steps a 24-bit candidate key through the shared arc4 decrypt core and launches one decryption per key using the en/rdy handshake.
- Snoops the core's plaintext-memory writes and declares a key valid when every message byte is printable ASCII.
- Sits between the top-level (KEY/HEX/LEDR glue) and the arc4 instance. The STEP parameter lets two schedulers split the keyspace (even/odd).

---
 rtl/crack_sched.sv | 117 +++++++++++
 1 files changed

// File: rtl/crack_sched.sv
// Key-search scheduler: walks candidate keys through a shared arc4 core and
// flags the first key whose decrypted message is entirely printable ASCII.
module crack_sched #(
   parameter int              KEY_W     = 24,
   parameter logic [KEY_W-1:0] KEY_START = '0,
   parameter logic [KEY_W-1:0] KEY_STEP  = KEY_W'(1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             rdy,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   output logic             done,
   output logic [KEY_W-1:0] tries,
   output logic             arc4_en,
   input  logic             arc4_rdy,
   input  logic             pt_wren,
   input  logic [7:0]       pt_addr,
   input  logic [7:0]       pt_wrdata
);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, EVAL} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             bad;
   logic             skip;
   logic [KEY_W:0]   key_sum;
   logic             pt_bad;
   logic             run_done;

   // Extra top bit carries out when the next candidate would wrap the keyspace.
   assign key_sum  = {1'b0, key} + {1'b0, KEY_STEP};
   assign pt_bad   = pt_wren && (pt_addr != 8'h00) &&
                     ((pt_wrdata < 8'h20) || (pt_wrdata > 8'h7E));
   assign run_done = (state == RUN) && !skip && arc4_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      arc4_en   = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (en) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            if (arc4_rdy) begin
               arc4_en   = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (run_done) state_nxt = EVAL;
         end
         EVAL: begin
            if (!bad || key_sum[KEY_W]) state_nxt = IDLE;
            else                        state_nxt = LAUNCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key       <= KEY_START;
         key_valid <= 1'b0;
         done      <= 1'b0;
         tries     <= '0;
         bad       <= 1'b0;
         skip      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  key       <= KEY_START;
                  tries     <= '0;
                  bad       <= 1'b0;
                  key_valid <= 1'b0;
                  done      <= 1'b0;
               end
            end
            LAUNCH: begin
               // The core still shows rdy=1 the cycle after its start pulse.
               if (arc4_rdy) skip <= 1'b1;
            end
            RUN: begin
               skip <= 1'b0;
               if (pt_bad) bad <= 1'b1;
               if (run_done && (tries != '1)) tries <= tries + KEY_W'(1);
            end
            EVAL: begin
               if (!bad) begin
                  key_valid <= 1'b1;
                  done      <= 1'b1;
               end else if (key_sum[KEY_W]) begin
                  done <= 1'b1;
               end else begin
                  key <= key_sum[KEY_W-1:0];
                  bad <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
